// File: rtl/cmd_sched_if.sv
// Bundle between cmd_sched and its neighbours: UART wrapper, tour sequencer and cmd_proc.
// master drives the requests and acknowledgements into the scheduler; slave is the scheduler.
interface cmd_sched_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_UART;
  logic [15:0] tour_cmd;
  logic        tour_req;
  logic        tour_last;
  logic        tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        q_full;

  modport master (
    output cmd_UART, cmd_rdy_UART, tour_cmd, tour_req, tour_last, clr_cmd_rdy, send_resp,
    input  clr_UART, tour_ack, cmd, cmd_rdy, resp, resp_vld, q_full
  );

  modport slave (
    input  cmd_UART, cmd_rdy_UART, tour_cmd, tour_req, tour_last, clr_cmd_rdy, send_resp,
    output clr_UART, tour_ack, cmd, cmd_rdy, resp, resp_vld, q_full
  );
endinterface

// File: rtl/cmd_sched.sv
// Command scheduler: queues UART commands in a 4-deep FIFO and arbitrates them
// against tour-sequencer commands onto one cmd/cmd_rdy channel toward cmd_proc.
module cmd_sched (
  input  logic       clk,
  input  logic       rst_n,
  cmd_sched_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam logic SRC_UART = 1'b0;
  localparam logic SRC_TOUR = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  logic              armed;
  logic              clr_uart_q;
  logic              src;
  logic              tour_last_q;
  logic              last_grant;
  logic [DATA_W-1:0] cmd_q;
  logic [7:0]        resp_q;
  logic              resp_vld_q;
  logic              q_empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              grant;
  logic              grant_tour;
  logic              done;
  logic              tour_ack;

  function automatic logic [7:0] resp_code(input logic from_tour, input logic last_move);
    return (!from_tour || last_move) ? 8'hA5 : 8'h5A;
  endfunction

  assign q_empty = (count == 3'd0);
  assign full    = (count == 3'd4);

  // A push needs a fresh cmd_rdy_UART level (armed) and a free slot; a pop in the
  // same cycle does not free a slot for a push when the queue is full.
  assign push = bus.cmd_rdy_UART && !clr_uart_q && armed && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      armed      <= 1'b1;
      clr_uart_q <= 1'b0;
    end else begin
      clr_uart_q <= push;
      if (push)
        armed <= 1'b0;
      else if (!bus.cmd_rdy_UART)
        armed <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.cmd_UART;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_tour = 1'b0;
    pop        = 1'b0;
    tour_ack   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // On contention the source that did not win last time is served.
        if (bus.tour_req && !q_empty) begin
          grant      = 1'b1;
          grant_tour = (last_grant == SRC_UART);
        end else if (bus.tour_req) begin
          grant      = 1'b1;
          grant_tour = 1'b1;
        end else if (!q_empty) begin
          grant      = 1'b1;
        end
        if (grant)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.clr_cmd_rdy) begin
          state_nxt = BUSY;
          pop       = (src == SRC_UART);
          tour_ack  = (src == SRC_TOUR);
        end
      end
      BUSY: begin
        if (bus.send_resp) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src         <= SRC_UART;
      tour_last_q <= 1'b0;
      last_grant  <= SRC_UART;
      cmd_q       <= '0;
      resp_q      <= 8'h5A;
      resp_vld_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_vld_q <= done;
      if (grant) begin
        cmd_q       <= grant_tour ? bus.tour_cmd : mem[rd_ptr];
        src         <= grant_tour;
        tour_last_q <= grant_tour && bus.tour_last;
      end
      if (done) begin
        resp_q     <= resp_code(src, tour_last_q);
        last_grant <= src;
      end
    end
  end

  assign bus.clr_UART = clr_uart_q;
  assign bus.tour_ack = tour_ack;
  assign bus.cmd      = cmd_q;
  assign bus.cmd_rdy  = (state == ISSUE);
  assign bus.resp     = resp_q;
  assign bus.resp_vld = resp_vld_q;
  assign bus.q_full   = full;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched: UART path, tour path, arbitration, full queue, reset.
module tb_cmd_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  cmd_sched_if bus();
  cmd_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one UART command and wait (bounded) for clr_UART, then release the level.
  task automatic uart_push(input logic [15:0] data, output bit ok);
    ok = 1'b0;
    bus.cmd_UART     = data;
    bus.cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.clr_UART === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.cmd_rdy_UART = 1'b0;
    tick();
  endtask

  task automatic take(output logic ack);
    bus.clr_cmd_rdy = 1'b1;
    #1 ack = bus.tour_ack;
    tick();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic finish_cmd();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] got;
    logic [28:0] want;
    rst_n = 1'b0;
    bus.cmd_UART = '0; bus.cmd_rdy_UART = 1'b0; bus.tour_cmd = '0; bus.tour_req = 1'b0;
    bus.tour_last = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    tick(); tick();
    want = {16'h0000, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    got  = {bus.cmd, bus.cmd_rdy, bus.clr_UART, bus.tour_ack, bus.resp, bus.resp_vld, bus.q_full};
    checks++; if (got !== want) begin errors++; $display("FAIL reset_outputs got %h want %h", got, want); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_idle cmd_rdy got %b want 0", bus.cmd_rdy); end
  endtask

  task automatic test_uart_only();
    logic ack;
    bus.cmd_UART = 16'h2001; bus.cmd_rdy_UART = 1'b1;
    tick();
    checks++; if (bus.clr_UART !== 1'b1) begin errors++; $display("FAIL uart_clr got %b want 1", bus.clr_UART); end
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL uart_early_rdy got %b want 0", bus.cmd_rdy); end
    bus.cmd_rdy_UART = 1'b0;
    tick();
    checks++; if (bus.clr_UART !== 1'b0) begin errors++; $display("FAIL uart_clr_pulse got %b want 0", bus.clr_UART); end
    checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h2001) begin
      errors++; $display("FAIL uart_issue rdy %b cmd %h want 1 2001", bus.cmd_rdy, bus.cmd); end
    take(ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL uart_no_tour_ack got %b want 0", ack); end
    tick();
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL uart_busy_rdy got %b want 0", bus.cmd_rdy); end
    finish_cmd();
    checks++; if (bus.resp_vld !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++; $display("FAIL uart_resp vld %b resp %h want 1 a5", bus.resp_vld, bus.resp); end
    tick();
    checks++; if (bus.resp_vld !== 1'b0) begin errors++; $display("FAIL uart_resp_pulse got %b want 0", bus.resp_vld); end
  endtask

  task automatic test_tour();
    logic ack;
    logic [7:0] want;
    for (int l = 0; l < 2; l++) begin
      want = (l == 1) ? 8'hA5 : 8'h5A;
      bus.tour_cmd = 16'h37F2; bus.tour_last = (l == 1); bus.tour_req = 1'b1;
      tick();
      checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h37F2) begin
        errors++; $display("FAIL tour_issue l=%0d rdy %b cmd %h want 1 37f2", l, bus.cmd_rdy, bus.cmd); end
      // Flip tour_last after the grant: the response must follow the latched value.
      bus.tour_last = (l == 0);
      take(ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL tour_ack l=%0d got %b want 1", l, ack); end
      bus.tour_req = 1'b0;
      tick();
      finish_cmd();
      checks++; if (bus.resp_vld !== 1'b1 || bus.resp !== want) begin
        errors++; $display("FAIL tour_resp l=%0d vld %b resp %h want 1 %h", l, bus.resp_vld, bus.resp, want); end
      bus.tour_last = 1'b0;
      tick();
    end
  endtask

  task automatic test_ignore_and_no_abort();
    logic ack;
    bus.send_resp = 1'b1; bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.send_resp = 1'b0; bus.clr_cmd_rdy = 1'b0;
    tick();
    checks++; if (bus.resp_vld !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore vld %b rdy %b want 0 0", bus.resp_vld, bus.cmd_rdy); end
    bus.tour_cmd = 16'h1234; bus.tour_last = 1'b1; bus.tour_req = 1'b1;
    tick();
    bus.tour_req = 1'b0; bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    tick();
    checks++; if (bus.resp_vld !== 1'b0 || bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h1234) begin
      errors++; $display("FAIL issue_hold vld %b rdy %b cmd %h want 0 1 1234", bus.resp_vld, bus.cmd_rdy, bus.cmd); end
    take(ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL no_abort_ack got %b want 1", ack); end
    take(ack);
    checks++; if (ack !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore ack %b rdy %b want 0 0", ack, bus.cmd_rdy); end
    finish_cmd();
    checks++; if (bus.resp_vld !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++; $display("FAIL no_abort_resp vld %b resp %h want 1 a5", bus.resp_vld, bus.resp); end
    bus.tour_last = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic ack;
    bit ok;
    logic [15:0] order [4];
    logic        is_tour [4];
    order   = '{16'hA001, 16'h1001, 16'hA002, 16'h1002};
    is_tour = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.tour_cmd = 16'hA001; bus.tour_last = 1'b0; bus.tour_req = 1'b1;
    bus.cmd_UART = 16'h1001; bus.cmd_rdy_UART = 1'b1;
    tick();
    bus.cmd_rdy_UART = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== order[k]) begin
        errors++; $display("FAIL contention_order k=%0d rdy %b cmd %h want 1 %h", k, bus.cmd_rdy, bus.cmd, order[k]); end
      take(ack);
      checks++; if (ack !== is_tour[k]) begin
        errors++; $display("FAIL contention_ack k=%0d got %b want %b", k, ack, is_tour[k]); end
      if (k == 0) begin
        bus.tour_cmd = 16'hA002;
        uart_push(16'h1002, ok);
        checks++; if (!ok) begin errors++; $display("FAIL contention_push got no clr_UART want clr_UART"); end
      end
      if (k == 2) bus.tour_req = 1'b0;
      finish_cmd();
      checks++; if (bus.cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL contention_gap k=%0d rdy %b want 0", k, bus.cmd_rdy); end
      tick();
    end
    tick();
  endtask

  task automatic test_full();
    logic ack;
    bit ok;
    int n;
    bus.tour_cmd = 16'hB000; bus.tour_last = 1'b0; bus.tour_req = 1'b1;
    tick();
    take(ack);
    bus.tour_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      uart_push(16'hC000 + 16'(i), ok);
      checks++; if (!ok || bus.q_full !== (i == 3)) begin
        errors++; $display("FAIL full_fill i=%0d ok %b q_full %b want 1 %b", i, ok, bus.q_full, (i == 3)); end
    end
    bus.cmd_UART = 16'hC004; bus.cmd_rdy_UART = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.clr_UART === 1'b1) n++;
    end
    checks++; if (n != 0 || bus.q_full !== 1'b1) begin
      errors++; $display("FAIL full_block clr_count %0d q_full %b want 0 1", n, bus.q_full); end
    finish_cmd();
    tick();
    checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hC000) begin
      errors++; $display("FAIL full_first rdy %b cmd %h want 1 c000", bus.cmd_rdy, bus.cmd); end
    take(ack);
    checks++; if (bus.clr_UART !== 1'b0 || bus.q_full !== 1'b0) begin
      errors++; $display("FAIL full_pop_cycle clr %b q_full %b want 0 0", bus.clr_UART, bus.q_full); end
    tick();
    checks++; if (bus.clr_UART !== 1'b1 || bus.q_full !== 1'b1) begin
      errors++; $display("FAIL full_retry clr %b q_full %b want 1 1", bus.clr_UART, bus.q_full); end
    bus.cmd_rdy_UART = 1'b0;
    finish_cmd();
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hC000 + 16'(i)) begin
        errors++; $display("FAIL full_drain i=%0d rdy %b cmd %h want 1 %h", i, bus.cmd_rdy, bus.cmd, 16'hC000 + 16'(i)); end
      take(ack);
      finish_cmd();
    end
    tick(); tick();
    checks++; if (bus.cmd_rdy !== 1'b0 || bus.q_full !== 1'b0) begin
      errors++; $display("FAIL full_empty rdy %b q_full %b want 0 0", bus.cmd_rdy, bus.q_full); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [28:0] got;
    logic [28:0] want;
    for (int i = 0; i < 3; i++) uart_push(16'hD000 + 16'(i), ok);
    checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hD000) begin
      errors++; $display("FAIL rst_mid_setup rdy %b cmd %h want 1 d000", bus.cmd_rdy, bus.cmd); end
    bus.tour_req = 1'b1; bus.tour_cmd = 16'h4444;
    #3 rst_n = 1'b0;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    want = {16'h0000, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    got  = {bus.cmd, bus.cmd_rdy, bus.clr_UART, bus.tour_ack, bus.resp, bus.resp_vld, bus.q_full};
    checks++; if (got !== want) begin errors++; $display("FAIL rst_mid_outputs got %h want %h", got, want); end
    tick();
    checks++; if (bus.tour_ack !== 1'b0 || bus.resp_vld !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pulses ack %b vld %b want 0 0", bus.tour_ack, bus.resp_vld); end
    bus.tour_req = 1'b0; bus.clr_cmd_rdy = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_discard rdy %b want 0", bus.cmd_rdy); end
    uart_push(16'hE000, ok);
    checks++; if (!ok || bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hE000) begin
      errors++; $display("FAIL rst_mid_fresh ok %b rdy %b cmd %h want 1 1 e000", ok, bus.cmd_rdy, bus.cmd); end
  endtask

  initial begin
    test_reset();
    test_uart_only();
    test_tour();
    test_ignore_and_no_abort();
    test_contention();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named clk and rst_n.
REQ-002 clk  input  1  50MHz system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_UART  input  16  command from UART wrapper.
REQ-005 cmd_rdy_UART  input  1  UART command valid; level, held until clr_UART.
REQ-006 clr_UART  output  1  one-cycle pulse: UART command accepted into queue.
REQ-007 tour_cmd  input  16  command from tour sequencer.
REQ-008 tour_req  input  1  tour command valid; level, held until tour_ack.
REQ-009 tour_last  input  1  qualifies tour_cmd as last move of tour.
REQ-010 tour_ack  output  1  one-cycle pulse: tour command taken by cmd_proc.
REQ-011 cmd  output  16  command presented to cmd_proc.
REQ-012 cmd_rdy  output  1  command valid to cmd_proc.
REQ-013 clr_cmd_rdy  input  1  cmd_proc has consumed cmd.
REQ-014 send_resp  input  1  cmd_proc finished executing current command.
REQ-015 resp  output  8  response byte: 8'hA5 done, 8'h5A in progress.
REQ-016 resp_vld  output  1  one-cycle pulse, resp valid.
REQ-017 q_full  output  1  UART queue holds 4 entries.

Function
REQ-018 UART queue SHALL be a 4-entry x 16-bit FIFO with 3-bit occupancy count 0..4; q_full = (count==4).
REQ-019 Push: when cmd_rdy_UART=1, clr_UART=0 in the current cycle, and count<4, cmd_UART SHALL be written and clr_UART pulsed high the next cycle; no second push before cmd_rdy_UART deasserts and reasserts.
REQ-020 When full, no push and no clr_UART; a push in the same cycle as a pop SHALL NOT be allowed when count==4 (push retried next cycle).
REQ-021 Push and pop in the same cycle with 0<count<4 SHALL leave count unchanged and preserve FIFO order; pointers wrap modulo 4.
REQ-022 Arbiter SHALL be a 3-state FSM: IDLE, ISSUE, BUSY.
REQ-023 IDLE: if tour_req and queue non-empty both pending, grant the requester not granted last (last_grant flag, reset = UART so tour wins first); else grant the single pending requester; else remain.
REQ-024 On grant, cmd register SHALL load tour_cmd or queue head, grant source and tour_last SHALL be latched, and FSM SHALL enter ISSUE.
REQ-025 ISSUE: cmd_rdy=1, cmd stable; on clr_cmd_rdy=1 go to BUSY; if tour grant, tour_ack pulses that cycle; if UART grant, queue pops that cycle.
REQ-026 BUSY: cmd_rdy=0; on send_resp=1, registered resp/resp_vld SHALL appear the next cycle, FSM returns to IDLE, last_grant updated.
REQ-027 resp SHALL be 8'hA5 if source was UART or latched tour_last=1, else 8'h5A.
REQ-028 Grant-to-cmd_rdy latency SHALL be 1 cycle; back-to-back commands SHALL have minimum 1 IDLE cycle between send_resp and next cmd_rdy.
REQ-029 send_resp or clr_cmd_rdy arriving in an unexpected state SHALL be ignored.
REQ-030 tour_req deassertion during ISSUE SHALL NOT abort the command; issued command completes.

Reset
REQ-031 On rst_n=0: FSM=IDLE, count=0, pointers=0, cmd=16'h0000, cmd_rdy=0, clr_UART=0, tour_ack=0, resp=8'h5A, resp_vld=0, last_grant=UART.
REQ-032 Reset asserted mid-operation SHALL discard queue contents and in-flight command with no ack pulse emitted.

Verification
REQ-033 UART only: cmd_UART=16'h2001 valid -> clr_UART pulse, cmd_rdy with cmd=16'h2001 two cycles after valid; send_resp -> resp=8'hA5, resp_vld pulse.
REQ-034 Tour only: tour_cmd=16'h37F2, tour_last=0 -> cmd=16'h37F2, tour_ack at clr_cmd_rdy, resp=8'h5A; repeat with tour_last=1 -> resp=8'hA5.
REQ-035 Contention: tour_req held plus 2 UART entries queued -> issue order tour, UART, tour, UART.
REQ-036 Full queue: 5 UART commands while BUSY -> q_full=1 after 4th, 5th gets no clr_UART until first pop, then accepted; output order equals input order.
REQ-037 Reset during ISSUE with 3 queued -> all outputs at reset values, count=0, no tour_ack/resp_vld.
